// File: rtl/sample_fetch_engine.sv
// Read-side streaming engine: walks a sample RAM address range (one-shot or looped)
// through a synchronous read port and presents the words as a valid/ready stream.
module sample_fetch_engine #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] loop_addr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] end_q;
    logic [ADDR_WIDTH-1:0] loop_q;
    logic                  loop_on;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  iss_q;   // ram_addr was freshly issued this cycle
    logic                  dv_q;    // ram_dout carries a requested word this cycle

    logic                  pop_c;
    logic                  push_c;
    logic [CRD_W-1:0]      credit_c;
    logic                  can_issue_c;
    logic [ADDR_WIDTH-1:0] next_addr_c;
    logic                  start_loop_c;
    logic                  start_last_c;

    assign sample_valid = (count != '0);
    assign sample_data  = mem[rd_ptr];
    assign pop_c        = sample_valid && sample_ready;
    assign push_c       = dv_q;

    // Both reads in the pipe are reserved so the FIFO can never overflow.
    assign credit_c    = CRD_W'(count) + CRD_W'(iss_q) + CRD_W'(dv_q);
    assign can_issue_c = (state == FETCH) && (credit_c < CRD_W'(FIFO_DEPTH));

    // Only increments when ram_addr != end_q, so the top address never wraps.
    assign next_addr_c  = (ram_addr == end_q) ? loop_q : ram_addr + ADDR_WIDTH'(1);
    assign start_loop_c = loop_en && (loop_addr >= start_addr) && (loop_addr <= end_addr);
    assign start_last_c = (start_addr == end_addr) && !start_loop_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            end_q    <= '0;
            loop_q   <= '0;
            loop_on  <= 1'b0;
            ram_addr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            iss_q    <= 1'b0;
            dv_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                iss_q  <= 1'b0;
                dv_q   <= 1'b0;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) begin
                    mem[wr_ptr] <= ram_dout;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
                dv_q  <= iss_q;
                iss_q <= 1'b0;

                case (state)
                    IDLE: begin
                        if (start) begin
                            if (start_addr <= end_addr) begin
                                end_q    <= end_addr;
                                loop_q   <= loop_addr;
                                loop_on  <= start_loop_c;
                                ram_addr <= start_addr;
                                iss_q    <= 1'b1;
                                busy     <= 1'b1;
                                state    <= start_last_c ? DRAIN : FETCH;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        if (can_issue_c) begin
                            ram_addr <= next_addr_c;
                            iss_q    <= 1'b1;
                            if (!loop_on && (next_addr_c == end_q)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if ((count == '0) && !iss_q && !dv_q) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_fetch_engine.sv
// Directed bench for sample_fetch_engine; the RAM returns 16'hC000 ^ addr[15:0].
module tb_sample_fetch_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [18:0] start_addr;
    logic [18:0] end_addr;
    logic        loop_en;
    logic [18:0] loop_addr;
    logic [18:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;

    sample_fetch_engine #(
        .ADDR_WIDTH(19),
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .loop_en      (loop_en),
        .loop_addr    (loop_addr),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= 16'hC000 ^ ram_addr[15:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [18:0] s, input logic [18:0] e,
                        input logic lp, input logic [18:0] l);
        start_addr = s;
        end_addr   = e;
        loop_en    = lp;
        loop_addr  = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Collects n transfers, checking order and hold-while-stalled; counts done pulses seen.
    task automatic stream(input string tag, input logic [18:0] s, input logic [18:0] e,
                          input logic [18:0] l, input bit lp, input int n, input bit rnd,
                          output int dn);
        logic [18:0] a;
        logic [15:0] hold;
        bit          stall;
        int          got;
        int          cyc;
        a = s; hold = '0; stall = 1'b0; got = 0; cyc = 0; dn = 0;
        while (got < n && cyc < 400) begin
            if (done) dn++;
            if (stall) chk({tag, "_hold"}, {15'd0, sample_valid, sample_data}, {16'd1, hold});
            sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sample_valid && sample_ready) begin
                chk({tag, "_data"}, {16'd0, sample_data}, {16'd0, 16'hC000 ^ a[15:0]});
                a     = (a == e) ? l : a + 19'd1;
                got++;
                stall = 1'b0;
            end else begin
                stall = sample_valid;
                hold  = sample_data;
            end
            step();
            cyc++;
        end
        chk({tag, "_count"}, got, n);
    endtask

    task automatic wait_done(input string tag, input int cycles);
        int dn;
        dn = 0;
        sample_ready = 1'b1;
        repeat (cycles) begin
            if (done) dn++;
            step();
        end
        chk({tag, "_done_once"}, dn, 1);
        chk({tag, "_idle"}, {30'd0, busy, sample_valid}, 32'd0);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
        start_addr = '0; end_addr = '0; loop_en = 1'b0; loop_addr = '0;
        #2;
        chk("reset_outputs", {ram_addr, sample_data, sample_valid, busy, done},
            {19'd0, 16'd0, 3'd0});
        step(); step();
        rst_n = 1'b1;
        step();

        // One-shot latency and throughput
        sample_ready = 1'b1;
        kick(19'h100, 19'h103, 1'b0, 19'h0);
        chk("os_c1_addr", ram_addr, 19'h100);
        chk("os_c1_busy_valid", {busy, sample_valid}, 2'b10);
        step();
        chk("os_c2_valid", sample_valid, 1'b0);
        step();
        chk("os_c3", {sample_valid, sample_data}, {1'b1, 16'hC100});
        step();
        chk("os_c4", {sample_valid, sample_data}, {1'b1, 16'hC101});
        step();
        chk("os_c5", {sample_valid, sample_data}, {1'b1, 16'hC102});
        step();
        chk("os_c6", {sample_valid, sample_data}, {1'b1, 16'hC103});
        step();
        chk("os_c7_valid", sample_valid, 1'b0);
        wait_done("os", 6);

        // Backpressure with random ready
        kick(19'h200, 19'h20F, 1'b0, 19'h0);
        stream("bp", 19'h200, 19'h20F, 19'h0, 1'b0, 16, 1'b1, dn);
        chk("bp_no_early_done", dn, 0);
        wait_done("bp", 10);

        // Looped playback, stopped after 9 samples
        kick(19'h10, 19'h13, 1'b1, 19'h12);
        stream("loop", 19'h10, 19'h13, 19'h12, 1'b1, 9, 1'b0, dn);
        chk("loop_no_done", dn, 0);
        chk("loop_still_busy", busy, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_stop", {sample_valid, busy, done}, 3'b000);
        step();
        chk("loop_stop_nodone", {sample_valid, busy, done}, 3'b000);

        // Top-of-memory single word, no wrap
        kick(19'h7FFFF, 19'h7FFFF, 1'b0, 19'h0);
        stream("top", 19'h7FFFF, 19'h7FFFF, 19'h0, 1'b0, 1, 1'b0, dn);
        wait_done("top", 6);
        chk("top_addr_hold", ram_addr, 19'h7FFFF);

        // start > end: no reads, done next cycle
        kick(19'h50, 19'h40, 1'b0, 19'h0);
        chk("inv_done", {busy, done, sample_valid}, 3'b010);
        chk("inv_addr_hold", ram_addr, 19'h7FFFF);
        step();
        chk("inv_done_pulse", {busy, done}, 2'b00);

        // loop_addr outside range behaves one-shot
        kick(19'h30, 19'h32, 1'b1, 19'h40);
        stream("lpout", 19'h30, 19'h32, 19'h0, 1'b0, 3, 1'b0, dn);
        wait_done("lpout", 6);

        // start while busy is ignored
        sample_ready = 1'b0;
        kick(19'h60, 19'h63, 1'b0, 19'h0);
        step(); step();
        kick(19'h00, 19'h05, 1'b0, 19'h0);
        stream("rebusy", 19'h60, 19'h63, 19'h0, 1'b0, 4, 1'b1, dn);
        wait_done("rebusy", 8);

        // stop and start in the same cycle: stop wins
        sample_ready = 1'b0;
        kick(19'h70, 19'h7F, 1'b0, 19'h0);
        step(); step();
        stop = 1'b1;
        kick(19'h90, 19'h9F, 1'b0, 19'h0);
        stop = 1'b0;
        chk("stst_idle", {sample_valid, busy, done}, 3'b000);
        step(); step();
        chk("stst_no_restart", {sample_valid, busy, done}, 3'b000);

        // Asynchronous reset mid-fetch, then clean restart
        sample_ready = 1'b1;
        kick(19'h80, 19'h8F, 1'b0, 19'h0);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {ram_addr, sample_data, sample_valid, busy, done},
            {19'd0, 16'd0, 3'd0});
        step();
        rst_n = 1'b1;
        step();
        kick(19'h100, 19'h101, 1'b0, 19'h0);
        stream("rst_restart", 19'h100, 19'h101, 19'h0, 1'b0, 2, 1'b0, dn);
        wait_done("rst_restart", 6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
